probe_event_arbiter: RTL

PROBE_EVENT_ARBITER -- requirements
Module: probe_event_arbiter

---
 rtl/probe_event_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/probe_event_arbiter.sv
// probe_event_arbiter
//   Watches N_CH probed signals, turns each value change on an enabled
//   channel into an event record, and serialises the records through a
//   single valid/ready output using a round-robin pick among channels that
//   have an unreported change. A newer change on a channel whose previous
//   change is still unreported overwrites it and is counted as dropped.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   sig_in     in   N_CH*WIDTH probed values, channel c at [c*WIDTH +: WIDTH]
//   ch_en      in   N_CH per-channel enable for new events
//   evt_valid  out  record available
//   evt_ready  in   consumer accepts record when evt_valid && evt_ready
//   evt_chan   out  4-bit channel index of the record
//   evt_value  out  WIDTH channel value carried by the record
//   evt_seq    out  16-bit record sequence number (first record is 1)
//   change_cnt out  32-bit total detected changes (wrapping)
//   drop_cnt   out  16-bit overwritten changes (saturating)
module probe_event_arbiter #(
  parameter int N_CH  = 8,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] sig_in,
  input  logic [N_CH-1:0]       ch_en,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [3:0]            evt_chan,
  output logic [WIDTH-1:0]      evt_value,
  output logic [15:0]           evt_seq,
  output logic [31:0]           change_cnt,
  output logic [15:0]           drop_cnt
);

  logic             r_armed;
  logic [WIDTH-1:0] r_prev [N_CH];
  logic [WIDTH-1:0] r_val  [N_CH];
  logic [N_CH-1:0]  r_pend;
  logic [3:0]       r_rr_ptr;

  logic [WIDTH-1:0] w_slice [N_CH];
  logic [N_CH-1:0]  w_change;
  logic [N_CH-1:0]  w_grant;
  logic [N_CH-1:0]  w_drop;
  logic [N_CH-1:0]  w_rot;
  logic             w_load;
  logic             w_found;
  logic [4:0]       w_off;
  logic [4:0]       w_sum;
  logic [3:0]       w_win;
  logic [3:0]       w_rr_next;
  logic [WIDTH-1:0] w_win_val;
  logic [4:0]       w_n_change;
  logic [4:0]       w_n_drop;
  logic [16:0]      w_drop_sum;

  // The output register may take a new record when empty or being consumed.
  assign w_load = !evt_valid || evt_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign w_slice[gi]  = sig_in[gi*WIDTH +: WIDTH];
      // Nothing is flagged until the first post-reset edge has loaded prev.
      assign w_change[gi] = r_armed && ch_en[gi] && (w_slice[gi] != r_prev[gi]);
      assign w_grant[gi]  = w_load && w_found && (w_win == 4'(gi));
      // A change that lands on a pending, not-just-granted channel replaces
      // the unreported value.
      assign w_drop[gi]   = w_change[gi] && r_pend[gi] && !w_grant[gi];
    end
  endgenerate

  // Rotate the pending vector so bit 0 corresponds to rr_ptr; the lowest set
  // bit of the rotated vector is then the round-robin winner's offset.
  assign w_rot = N_CH'({r_pend, r_pend} >> r_rr_ptr);

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    // Scan downward so the lowest offset is the one left standing.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_found = 1'b1;
        w_off   = 5'(i);
      end
    end
    w_sum     = {1'b0, r_rr_ptr} + w_off;
    w_win     = 4'((w_sum >= 5'(N_CH)) ? (w_sum - 5'(N_CH)) : w_sum);
    w_rr_next = (w_win == 4'(N_CH - 1)) ? 4'd0 : (w_win + 4'd1);
  end

  always_comb begin
    w_win_val  = '0;
    w_n_change = '0;
    w_n_drop   = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_win_val  = w_win_val | (r_val[c] & {WIDTH{w_grant[c]}});
      w_n_change = w_n_change + {4'd0, w_change[c]};
      w_n_drop   = w_n_drop + {4'd0, w_drop[c]};
    end
    w_drop_sum = {1'b0, drop_cnt} + {12'd0, w_n_drop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed    <= 1'b0;
      r_pend     <= '0;
      r_rr_ptr   <= '0;
      evt_valid  <= 1'b0;
      evt_chan   <= '0;
      evt_value  <= '0;
      evt_seq    <= '0;
      change_cnt <= '0;
      drop_cnt   <= '0;
      for (int c = 0; c < N_CH; c++) begin
        r_prev[c] <= '0;
        r_val[c]  <= '0;
      end
    end else begin
      r_armed <= 1'b1;
      for (int c = 0; c < N_CH; c++) begin
        r_prev[c] <= w_slice[c];
        if (w_change[c]) begin
          r_val[c] <= w_slice[c];
        end
      end
      // A change on the granted channel re-arms it with the new value; the
      // outgoing record has already captured the old one.
      r_pend     <= w_change | (r_pend & ~w_grant);
      change_cnt <= change_cnt + {27'd0, w_n_change};
      drop_cnt   <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      if (w_load) begin
        if (w_found) begin
          evt_valid <= 1'b1;
          evt_chan  <= w_win;
          evt_value <= w_win_val;
          evt_seq   <= evt_seq + 16'd1;
          r_rr_ptr  <= w_rr_next;
        end else begin
          evt_valid <= 1'b0;
        end
      end
    end
  end

endmodule
